mmcm_drp_reconfig: RTL and testbench

//  DRP master that reprograms an MMCME2_ADV at run time (output dividers, phase) via read-modify-write.

---
 rtl/mmcm_drp_reconfig_pkg.sv | 41 ++++
 rtl/mmcm_drp_reconfig_if.sv | 22 ++
 rtl/mmcm_drp_watchdog.sv | 28 ++
 rtl/mmcm_drp_reconfig.sv | 214 +++++++++++++++++++++
 tb/tb_mmcm_drp_reconfig.sv | 282 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mmcm_drp_reconfig_pkg.sv
// Shared types for the MMCME2 DRP reconfiguration master.
// Contents: FSM state encoding, DRP bus widths, well-known MMCME2 register addresses.
package mmcm_drp_pkg;

   localparam int DRP_ADDR_W = 7;
   localparam int DRP_DATA_W = 16;

   // MMCME2_ADV register map (subset used by typical divider/phase tables)
   localparam logic [DRP_ADDR_W-1:0] MMCM_CLKOUT0_REG1  = 7'h08;
   localparam logic [DRP_ADDR_W-1:0] MMCM_CLKOUT0_REG2  = 7'h09;
   localparam logic [DRP_ADDR_W-1:0] MMCM_CLKOUT1_REG1  = 7'h0A;
   localparam logic [DRP_ADDR_W-1:0] MMCM_CLKOUT1_REG2  = 7'h0B;
   localparam logic [DRP_ADDR_W-1:0] MMCM_CLKFBOUT_REG1 = 7'h14;
   localparam logic [DRP_ADDR_W-1:0] MMCM_CLKFBOUT_REG2 = 7'h15;
   localparam logic [DRP_ADDR_W-1:0] MMCM_POWER_REG     = 7'h28;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_ASSERT_RST,
      ST_RD,
      ST_RD_WAIT,
      ST_WR,
      ST_WR_WAIT,
      ST_VFY,
      ST_VFY_WAIT,
      ST_NEXT,
      ST_RELEASE,
      ST_LOCK_WAIT,
      ST_DONE
   } state_t;

   // A set mask bit keeps the current register bit; a clear bit takes the new data bit.
   function automatic logic [DRP_DATA_W-1:0] drp_merge(
      input logic [DRP_DATA_W-1:0] rd,
      input logic [DRP_DATA_W-1:0] mask,
      input logic [DRP_DATA_W-1:0] data
   );
      return (rd & mask) | (data & ~mask);
   endfunction

endpackage

// File: rtl/mmcm_drp_reconfig_if.sv
// DRP port bundle between the reconfiguration master and the MMCME2_ADV primitive.
interface mmcm_drp_reconfig_if;
   import mmcm_drp_pkg::*;

   logic [DRP_ADDR_W-1:0] drp_daddr;
   logic                  drp_den;
   logic                  drp_dwe;
   logic [DRP_DATA_W-1:0] drp_di;
   logic [DRP_DATA_W-1:0] drp_do;
   logic                  drp_drdy;

   modport master (
      output drp_daddr, drp_den, drp_dwe, drp_di,
      input  drp_do, drp_drdy
   );

   modport slave (
      input  drp_daddr, drp_den, drp_dwe, drp_di,
      output drp_do, drp_drdy
   );

endinterface

// File: rtl/mmcm_drp_watchdog.sv
// Clear/enable counter flagging its terminal count; used for DRDY and LOCKED timeouts.
module mmcm_drp_watchdog #(
   parameter int count_p = 255
) (
   input  logic clk_i,
   input  logic reset_i,
   input  logic i_clear,
   input  logic i_enable,
   output logic o_expired
);

   localparam int               CNT_W = $clog2(count_p + 1);
   localparam logic [CNT_W-1:0] TERM  = CNT_W'(count_p - 1);

   logic [CNT_W-1:0] r_count;

   // NOTE: sequential state uses <= so every flop samples pre-edge values.
   always_ff @(posedge clk_i) begin
      if (reset_i || i_clear) begin
         r_count <= '0;
      end else if (i_enable) begin
         r_count <= r_count + CNT_W'(1);
      end
   end

   assign o_expired = i_enable && (r_count == TERM);

endmodule

// File: rtl/mmcm_drp_reconfig.sv
// DRP master: holds the MMCM in reset, read-modify-writes a table of registers, then waits for LOCKED.
// Define MMCM_DRP_READBACK_EN to re-read and verify every written register.
module mmcm_drp_reconfig
   import mmcm_drp_pkg::*;
#(
   parameter int   entries_p      = 8,
   parameter int   lock_timeout_p = 65535,
   parameter int   drdy_timeout_p = 255,
   localparam int  IDX_W          = (entries_p > 1) ? $clog2(entries_p) : 1
) (
   input  logic                  clk_i,
   input  logic                  reset_i,
   input  logic                  start_i,
   output logic                  ready_o,
   output logic [IDX_W-1:0]      cfg_idx_o,
   input  logic [DRP_ADDR_W-1:0] cfg_addr_i,
   input  logic [DRP_DATA_W-1:0] cfg_mask_i,
   input  logic [DRP_DATA_W-1:0] cfg_data_i,
   mmcm_drp_reconfig_if.master   drp,
   output logic                  mmcm_reset_o,
   input  logic                  mmcm_locked_i,
   output logic                  done_o,
   output logic                  error_o
);

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(entries_p - 1);

   state_t                r_state, w_state_nxt;
   logic                  r_ready, w_ready_nxt;
   logic [IDX_W-1:0]      r_idx, w_idx_nxt;
   logic [DRP_ADDR_W-1:0] r_daddr, w_daddr_nxt;
   logic                  r_den, w_den_nxt;
   logic                  r_dwe, w_dwe_nxt;
   logic [DRP_DATA_W-1:0] r_di, w_di_nxt;
   logic [DRP_DATA_W-1:0] r_rd, w_rd_nxt;
   logic                  r_mmcm_rst, w_mmcm_rst_nxt;
   logic                  r_done, w_done_nxt;
   logic                  r_error, w_error_nxt;

   logic w_drdy_wait, w_drdy_expired;
   logic w_lock_wait, w_lock_expired;

   assign w_drdy_wait = (r_state == ST_RD_WAIT) || (r_state == ST_WR_WAIT) ||
                        (r_state == ST_VFY_WAIT);
   assign w_lock_wait = (r_state == ST_LOCK_WAIT);

   // Counters sit at zero outside their wait state, so each wait starts from 0.
   mmcm_drp_watchdog #(.count_p(drdy_timeout_p)) u_drdy_wdog (
      .clk_i     (clk_i),
      .reset_i   (reset_i),
      .i_clear   (!w_drdy_wait),
      .i_enable  (w_drdy_wait),
      .o_expired (w_drdy_expired)
   );

   mmcm_drp_watchdog #(.count_p(lock_timeout_p)) u_lock_wdog (
      .clk_i     (clk_i),
      .reset_i   (reset_i),
      .i_clear   (!w_lock_wait),
      .i_enable  (w_lock_wait),
      .o_expired (w_lock_expired)
   );

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      // NOTE: every output of this block gets a default first, so no path can infer a latch.
      w_state_nxt    = r_state;
      w_idx_nxt      = r_idx;
      w_daddr_nxt    = r_daddr;
      w_den_nxt      = 1'b0;
      w_dwe_nxt      = 1'b0;
      w_di_nxt       = r_di;
      w_rd_nxt       = r_rd;
      w_mmcm_rst_nxt = r_mmcm_rst;
      w_error_nxt    = r_error;

      case (r_state)
         ST_IDLE: begin
            if (start_i) begin
               w_error_nxt = 1'b0;
               w_idx_nxt   = '0;
               w_state_nxt = ST_ASSERT_RST;
            end
         end
         ST_ASSERT_RST: begin
            w_mmcm_rst_nxt = 1'b1;
            w_state_nxt    = ST_RD;
         end
         ST_RD: begin
            w_den_nxt   = 1'b1;
            w_daddr_nxt = cfg_addr_i;
            w_state_nxt = ST_RD_WAIT;
         end
         ST_RD_WAIT: begin
            if (drp.drp_drdy) begin
               w_rd_nxt    = drp.drp_do;
               w_state_nxt = ST_WR;
            end else if (w_drdy_expired) begin
               w_error_nxt = 1'b1;
               w_state_nxt = ST_RELEASE;
            end
         end
         ST_WR: begin
            w_den_nxt   = 1'b1;
            w_dwe_nxt   = 1'b1;
            w_di_nxt    = drp_merge(r_rd, cfg_mask_i, cfg_data_i);
            w_state_nxt = ST_WR_WAIT;
         end
         ST_WR_WAIT: begin
            if (drp.drp_drdy) begin
`ifdef MMCM_DRP_READBACK_EN
               w_state_nxt = ST_VFY;
`else
               w_state_nxt = ST_NEXT;
`endif
            end else if (w_drdy_expired) begin
               w_error_nxt = 1'b1;
               w_state_nxt = ST_RELEASE;
            end
         end
`ifdef MMCM_DRP_READBACK_EN
         ST_VFY: begin
            w_den_nxt   = 1'b1;
            w_state_nxt = ST_VFY_WAIT;
         end
         ST_VFY_WAIT: begin
            if (drp.drp_drdy) begin
               if (drp.drp_do != r_di) begin
                  w_error_nxt = 1'b1;
               end
               w_state_nxt = ST_NEXT;
            end else if (w_drdy_expired) begin
               w_error_nxt = 1'b1;
               w_state_nxt = ST_RELEASE;
            end
         end
`endif
         ST_NEXT: begin
            if (r_idx == LAST_IDX) begin
               w_state_nxt = ST_RELEASE;
            end else begin
               w_idx_nxt   = r_idx + IDX_W'(1);
               w_state_nxt = ST_RD;
            end
         end
         ST_RELEASE: begin
            w_mmcm_rst_nxt = 1'b0;
            w_state_nxt    = ST_LOCK_WAIT;
         end
         ST_LOCK_WAIT: begin
            if (mmcm_locked_i) begin
               w_state_nxt = ST_DONE;
            end else if (w_lock_expired) begin
               w_error_nxt = 1'b1;
               w_state_nxt = ST_DONE;
            end
         end
         ST_DONE: begin
            w_state_nxt = ST_IDLE;
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase

      // Status flags follow the state being entered so they line up with it exactly.
      w_ready_nxt = (w_state_nxt == ST_IDLE);
      w_done_nxt  = (w_state_nxt == ST_DONE);
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         r_ready    <= 1'b1;
         r_idx      <= '0;
         r_daddr    <= '0;
         r_den      <= 1'b0;
         r_dwe      <= 1'b0;
         r_di       <= '0;
         r_rd       <= '0;
         r_mmcm_rst <= 1'b0;
         r_done     <= 1'b0;
         r_error    <= 1'b0;
      end else begin
         r_ready    <= w_ready_nxt;
         r_idx      <= w_idx_nxt;
         r_daddr    <= w_daddr_nxt;
         r_den      <= w_den_nxt;
         r_dwe      <= w_dwe_nxt;
         r_di       <= w_di_nxt;
         r_rd       <= w_rd_nxt;
         r_mmcm_rst <= w_mmcm_rst_nxt;
         r_done     <= w_done_nxt;
         r_error    <= w_error_nxt;
      end
   end

   assign ready_o       = r_ready;
   assign cfg_idx_o     = r_idx;
   assign drp.drp_daddr = r_daddr;
   assign drp.drp_den   = r_den;
   assign drp.drp_dwe   = r_dwe;
   assign drp.drp_di    = r_di;
   assign mmcm_reset_o  = r_mmcm_rst;
   assign done_o        = r_done;
   assign error_o       = r_error;

endmodule

// File: tb/tb_mmcm_drp_reconfig.sv
// Bench for mmcm_drp_reconfig: MMCM DRP/LOCKED model plus write and completion scoreboards.
module tb_mmcm_drp_reconfig;
   import mmcm_drp_pkg::*;

   localparam int ENTRIES = 2;
   localparam int LOCK_TO = 100;
   localparam int DRDY_TO = 16;
`ifdef MMCM_DRP_READBACK_EN
   localparam int DENS_PER_ENTRY = 3;
`else
   localparam int DENS_PER_ENTRY = 2;
`endif

   typedef struct packed {
      logic [DRP_ADDR_W-1:0] addr;
      logic [DRP_DATA_W-1:0] data;
   } wr_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic                  reset_i, start_i, ready_o;
   logic [0:0]            cfg_idx_o;
   logic [DRP_ADDR_W-1:0] cfg_addr_i;
   logic [DRP_DATA_W-1:0] cfg_mask_i, cfg_data_i;
   logic                  mmcm_reset_o, mmcm_locked_i, done_o, error_o;

   mmcm_drp_reconfig_if drp_if ();

   mmcm_drp_reconfig #(
      .entries_p      (ENTRIES),
      .lock_timeout_p (LOCK_TO),
      .drdy_timeout_p (DRDY_TO)
   ) dut (
      .clk_i         (clk),
      .reset_i       (reset_i),
      .start_i       (start_i),
      .ready_o       (ready_o),
      .cfg_idx_o     (cfg_idx_o),
      .cfg_addr_i    (cfg_addr_i),
      .cfg_mask_i    (cfg_mask_i),
      .cfg_data_i    (cfg_data_i),
      .drp           (drp_if),
      .mmcm_reset_o  (mmcm_reset_o),
      .mmcm_locked_i (mmcm_locked_i),
      .done_o        (done_o),
      .error_o       (error_o)
   );

   // Configuration table, combinational on cfg_idx_o
   logic [DRP_ADDR_W-1:0] tbl_addr [ENTRIES];
   logic [DRP_DATA_W-1:0] tbl_mask [ENTRIES];
   logic [DRP_DATA_W-1:0] tbl_data [ENTRIES];
   assign cfg_addr_i = tbl_addr[cfg_idx_o];
   assign cfg_mask_i = tbl_mask[cfg_idx_o];
   assign cfg_data_i = tbl_data[cfg_idx_o];

   bit no_drdy    = 1'b0;
   bit lock_hold  = 1'b0;
   bit corrupt_0a = 1'b0;

   // MMCM DRP model: 128x16 registers, DRDY three cycles after DEN
   logic [DRP_DATA_W-1:0] regs [128];
   logic [2:0]            rdy_sr = '0;
   logic [DRP_DATA_W-1:0] rd_q   = '0;
   int                    lock_cnt = 0;

   always @(posedge clk) begin
      if (reset_i) begin
         for (int i = 0; i < 128; i++) regs[i] <= '0;
         regs[7'h08] <= 16'hAAAA;
         regs[7'h0A] <= 16'h5555;
         rdy_sr      <= '0;
         rd_q        <= '0;
      end else begin
         rdy_sr <= {rdy_sr[1:0], drp_if.drp_den & ~no_drdy};
         if (drp_if.drp_den) begin
            if (drp_if.drp_dwe)
               regs[drp_if.drp_daddr] <= (corrupt_0a && drp_if.drp_daddr == 7'h0A) ?
                                         (drp_if.drp_di ^ 16'h0001) : drp_if.drp_di;
            else
               rd_q <= regs[drp_if.drp_daddr];
         end
      end
   end
   assign drp_if.drp_drdy = rdy_sr[2];
   assign drp_if.drp_do   = rd_q;

   always @(posedge clk) begin
      if (mmcm_reset_o) lock_cnt <= 0;
      else if (lock_cnt < 63) lock_cnt <= lock_cnt + 1;
   end
   assign mmcm_locked_i = !lock_hold && (lock_cnt >= 50);

   // Scoreboard and bookkeeping
   wr_t  exp_wr [$];
   logic exp_done [$];
   int   n_tests = 0, n_fail = 0;
   int   cyc = 0;
   int   den_cnt = 0, wr_cnt = 0, done_cnt = 0;
   int   last_den_cyc = 0, err_rise_cyc = 0, rst_fall_cyc = 0, done_cyc = 0;
   logic prev_den = 1'b0, prev_err = 1'b0, prev_rst = 1'b0;
   wr_t  mon_w;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (drp_if.drp_den === 1'b1) begin
         den_cnt++;
         last_den_cyc = cyc;
         check("den_single_cycle", 32'(prev_den), 32'd0);
      end
      if (drp_if.drp_dwe === 1'b1) check("dwe_with_den", 32'(drp_if.drp_den), 32'd1);
      if (drp_if.drp_den === 1'b1 && drp_if.drp_dwe === 1'b1) begin
         wr_cnt++;
         check("wr_rst_held", 32'(mmcm_reset_o), 32'd1);
         if (exp_wr.size() == 0) begin
            check("wr_unexpected", 32'(exp_wr.size()), 32'd1);
         end else begin
            mon_w = exp_wr.pop_front();
            check("wr_addr", 32'(drp_if.drp_daddr), 32'(mon_w.addr));
            check("wr_data", 32'(drp_if.drp_di), 32'(mon_w.data));
         end
      end
      if (error_o === 1'b1 && prev_err !== 1'b1) err_rise_cyc = cyc;
      if (prev_rst === 1'b1 && mmcm_reset_o === 1'b0) rst_fall_cyc = cyc;
      if (done_o === 1'b1) begin
         done_cnt++;
         done_cyc = cyc;
         if (exp_done.size() == 0) check("done_unexpected", 32'(exp_done.size()), 32'd1);
         else check("done_error", 32'(error_o), 32'(exp_done.pop_front()));
      end
      prev_den = drp_if.drp_den;
      prev_err = error_o;
      prev_rst = mmcm_reset_o;
   end

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic push_writes();
      wr_t w;
      for (int e = 0; e < ENTRIES; e++) begin
         w.addr = tbl_addr[e];
         w.data = (regs[tbl_addr[e]] & tbl_mask[e]) | (tbl_data[e] & ~tbl_mask[e]);
         exp_wr.push_back(w);
      end
   endtask

   task automatic check_reset(input string t);
      check({t, "_ready"},  32'(ready_o),           32'd1);
      check({t, "_idx"},    32'(cfg_idx_o),         32'd0);
      check({t, "_daddr"},  32'(drp_if.drp_daddr),  32'd0);
      check({t, "_den"},    32'(drp_if.drp_den),    32'd0);
      check({t, "_dwe"},    32'(drp_if.drp_dwe),    32'd0);
      check({t, "_di"},     32'(drp_if.drp_di),     32'd0);
      check({t, "_mrst"},   32'(mmcm_reset_o),      32'd0);
      check({t, "_done"},   32'(done_o),            32'd0);
      check({t, "_error"},  32'(error_o),           32'd0);
   endtask

   // One request with two ignored start pulses while busy; bounded wait for done_o.
   task automatic run(input logic exp_err, input logic expect_writes, input int budget);
      int d0;
      bit seen;
      check("ready_idle", 32'(ready_o), 32'd1);
      if (expect_writes) push_writes();
      exp_done.push_back(exp_err);
      d0 = done_cnt;
      start_i = 1'b1;
      step();
      start_i = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < budget && !seen; i++) begin
         start_i = (i == 4 || i == 20);
         if (i == 1) check("ready_busy", 32'(ready_o), 32'd0);
         if (i == 2) check("err_clear", 32'(error_o), 32'd0);
         step();
         if (done_cnt != d0) seen = 1'b1;
      end
      start_i = 1'b0;
      check("done_seen", 32'(seen), 32'd1);
      repeat (10) step();
      check("done_once", 32'(done_cnt - d0), 32'd1);
      check("wr_drained", 32'(exp_wr.size()), 32'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not finish, expected completion");
      $fatal(1);
   end

   initial begin
      int d0, w0, c0;
      bit reached;
      reset_i = 1'b1;
      start_i = 1'b0;
      tbl_addr[0] = 7'h08; tbl_mask[0] = 16'hFF00; tbl_data[0] = 16'h1234;
      tbl_addr[1] = 7'h0A; tbl_mask[1] = 16'h00FF; tbl_data[1] = 16'hBE00;
      repeat (3) step();
      check_reset("por");
      reset_i = 1'b0;
      repeat (60) step();

      // Normal two-entry program with stray start pulses
      d0 = den_cnt; w0 = wr_cnt;
      run(1'b0, 1'b1, 400);
      check("t1_reg08", 32'(regs[7'h08]), 32'h0000_AA34);
      check("t1_reg0a", 32'(regs[7'h0A]), 32'h0000_BE55);
      check("t2_writes", 32'(wr_cnt - w0), 32'd2);
      check("t2_dens", 32'(den_cnt - d0), 32'(ENTRIES * DENS_PER_ENTRY));

      // DRDY never returns
      no_drdy = 1'b1;
      d0 = den_cnt; c0 = cyc;
      run(1'b1, 1'b0, 400);
      no_drdy = 1'b0;
      check("t3_drdy_timeout", 32'(err_rise_cyc - last_den_cyc), 32'(DRDY_TO));
      check("t3_dens", 32'(den_cnt - d0), 32'd1);
      check("t3_rst_fell", 32'(rst_fall_cyc > c0), 32'd1);

      // LOCKED never rises, then a clean request clears the error
      lock_hold = 1'b1;
      run(1'b1, 1'b1, 400);
      lock_hold = 1'b0;
      check("t4_lock_timeout", 32'(done_cyc - rst_fall_cyc), 32'(LOCK_TO));
      run(1'b0, 1'b1, 400);

      // Synchronous reset while waiting on the second write
      push_writes();
      exp_done.push_back(1'b0);
      w0 = wr_cnt;
      start_i = 1'b1;
      step();
      start_i = 1'b0;
      reached = 1'b0;
      for (int i = 0; i < 200 && !reached; i++) begin
         step();
         if (wr_cnt == w0 + 2) reached = 1'b1;
      end
      check("t5_reach_wr1", 32'(reached), 32'd1);
      reset_i = 1'b1;
      step();
      check_reset("t5");
      exp_done.delete();
      exp_wr.delete();
      step();
      reset_i = 1'b0;
      repeat (10) step();
      run(1'b0, 1'b1, 400);
      check("t5_reg08", 32'(regs[7'h08]), 32'h0000_AA34);

`ifdef MMCM_DRP_READBACK_EN
      // Readback mismatch on 0x0A; the following entry is still written
      tbl_addr[0] = 7'h0A; tbl_mask[0] = 16'h00FF; tbl_data[0] = 16'hBE00;
      tbl_addr[1] = 7'h08; tbl_mask[1] = 16'hFF00; tbl_data[1] = 16'h1234;
      repeat (2) step();
      corrupt_0a = 1'b1;
      w0 = wr_cnt;
      run(1'b1, 1'b1, 400);
      corrupt_0a = 1'b0;
      check("t6_writes", 32'(wr_cnt - w0), 32'd2);
      check("t6_reg0a", 32'(regs[7'h0A]), 32'h0000_BE54);
      check("t6_reg08", 32'(regs[7'h08]), 32'h0000_AA34);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
